// File: rtl/if_stage_fifo.sv
// In-order {PC, Instruction} buffer between instruction fetch and decode.
// Fetch keeps pushing while decode is frozen. Flush or reset empties the buffer. An empty buffer presents a NOP bubble.
module if_stage_fifo #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 DEPTH     = 2,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hE000_0000,
    localparam int                PTR_W     = $clog2(DEPTH),
    localparam int                CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               freeze,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    PC_in,
    input  logic [INSTR_W-1:0] Instruction_in,
    output logic               out_valid,
    output logic [PC_W-1:0]    PC,
    output logic [INSTR_W-1:0] Instruction,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign out_valid = !empty;

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign in_ready = !full || (!freeze && !empty);
    assign pop      = !flush && !freeze && !empty;
    assign push     = !flush && in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; empty gating hides stale entries.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wr_ptr]    <= PC_in;
            instr_mem[wr_ptr] <= Instruction_in;
        end
    end

    assign PC          = empty ? '0        : pc_mem[rd_ptr];
    assign Instruction = empty ? NOP_INSTR : instr_mem[rd_ptr];

endmodule
